// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

    localparam int UART_DATA_W = 8;
    localparam int TIMER_W     = 28;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first set request strictly after last_grant, wrapping.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [IDX_W:0] idx_s;

    // Scan from the farthest candidate to the nearest so the nearest set request wins;
    // the wrap is an explicit compare so non-power-of-two counts never alias.
    always_comb begin
        winner  = '0;
        idx_s   = '0;
        any_req = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx_s  = {1'b0, last_grant} + (IDX_W+1)'(k);
            idx_s  = (idx_s >= (IDX_W+1)'(NUM_REQ)) ? idx_s - (IDX_W+1)'(NUM_REQ) : idx_s;
            winner = req[idx_s[IDX_W-1:0]] ? idx_s[IDX_W-1:0] : winner;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers.
// Optional wait-phase watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int              NUM_REQ        = 4,
    parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 28'd200000
) (
    input  logic                         clk_10ns,
    input  logic                         uart_reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ack,
    input  logic                         uart_tx_ready,
    output logic                         uart_tx_start,
    output logic [UART_DATA_W-1:0]       uart_transmit_data,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         arb_busy,
    output logic                         timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] last_grant_r;
    logic [IDX_W-1:0] winner_s;
    logic             any_req_s;
    logic             timeout_fire_s;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .winner     (winner_s),
        .any_req    (any_req_s)
    );

`ifdef UART_ARB_TIMEOUT_EN
    logic [TIMER_W-1:0] timer_r;
    logic               in_wait_s;

    assign in_wait_s      = (state_r == WAIT_BUSY) || (state_r == WAIT_DONE);
    assign timeout_fire_s = in_wait_s && (timer_r == TIMEOUT_CYCLES - 28'd1);

    // Wait-phase cycle counter, cleared on every state change and outside the wait states.
    always_ff @(posedge clk_10ns) begin
        if (uart_reset) begin
            timer_r <= '0;
        end else if (!in_wait_s || (state_nxt_s != state_r)) begin
            timer_r <= '0;
        end else begin
            timer_r <= timer_r + 28'd1;
        end
    end

    // Sticky abort flag; a legitimate ready transition on the same edge is not an abort.
    always_ff @(posedge clk_10ns) begin
        if (uart_reset) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_err | (timeout_fire_s &&
                ((state_r == WAIT_BUSY && uart_tx_ready) || (state_r == WAIT_DONE && !uart_tx_ready)));
        end
    end
`else
    logic [TIMER_W-1:0] unused_timeout_s;

    assign unused_timeout_s = TIMEOUT_CYCLES;
    assign timeout_fire_s   = 1'b0;

    // Without the watchdog the error flag is a register that never leaves 0.
    always_ff @(posedge clk_10ns) begin
        if (uart_reset) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
        end
    end
`endif

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:      state_nxt_s = (uart_tx_ready && any_req_s) ? LAUNCH : IDLE;
            LAUNCH:    state_nxt_s = WAIT_BUSY;
            WAIT_BUSY: state_nxt_s = !uart_tx_ready ? WAIT_DONE : (timeout_fire_s ? IDLE : WAIT_BUSY);
            WAIT_DONE: state_nxt_s = (uart_tx_ready || timeout_fire_s) ? IDLE : WAIT_DONE;
            default:   state_nxt_s = IDLE;
        endcase
    end

    // State, pointer and registered outputs; the byte only moves on the IDLE->LAUNCH grant.
    always_ff @(posedge clk_10ns) begin
        if (uart_reset) begin
            state_r            <= IDLE;
            last_grant_r       <= IDX_W'(NUM_REQ - 1);
            req_ack            <= '0;
            uart_tx_start      <= 1'b0;
            uart_transmit_data <= '0;
            grant_id           <= '0;
            arb_busy           <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            arb_busy <= (state_nxt_s != IDLE);
            if (state_r == IDLE && state_nxt_s == LAUNCH) begin
                uart_transmit_data <= req_data[winner_s*UART_DATA_W +: UART_DATA_W];
                req_ack            <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
                grant_id           <= winner_s;
                last_grant_r       <= winner_s;
                uart_tx_start      <= 1'b1;
            end else begin
                req_ack       <= '0;
                uart_tx_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter against a round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int N = 4;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int LONG_LOW = 12;
`else
    localparam int LONG_LOW = 100;
`endif

    logic           clk_10ns = 1'b0;
    logic           uart_reset;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_ack;
    logic           uart_tx_ready;
    logic           uart_tx_start;
    logic [7:0]     uart_transmit_data;
    logic [1:0]     grant_id;
    logic           arb_busy;
    logic           timeout_err;

    int total = 0;
    int bad   = 0;
    int lg_m;
    int w;
    int order [6] = '{0, 1, 2, 3, 0, 1};

    always #5 clk_10ns = ~clk_10ns;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (28'd20)
    ) dut (
        .clk_10ns           (clk_10ns),
        .uart_reset         (uart_reset),
        .req_valid          (req_valid),
        .req_data           (req_data),
        .req_ack            (req_ack),
        .uart_tx_ready      (uart_tx_ready),
        .uart_tx_start      (uart_tx_start),
        .uart_transmit_data (uart_transmit_data),
        .grant_id           (grant_id),
        .arb_busy           (arb_busy),
        .timeout_err        (timeout_err)
    );

    task automatic tick();
        @(posedge clk_10ns);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: first pending requester at distance 1..N from the last grant, modulo N.
    function automatic int model_pick(input logic [N-1:0] v, input int lg);
        int r = -1;
        for (int k = 1; k <= N; k++)
            if (r < 0 && v[(lg + k) % N]) r = (lg + k) % N;
        return r;
    endfunction

    task automatic do_reset();
        uart_reset = 1'b1;
        tick();
        tick();
        uart_reset = 1'b0;
        lg_m = N - 1;
    endtask

    // One complete frame: grant, launch, optional ready lag, busy period, return to idle.
    task automatic run_frame(input int win, input bit hold, input int lag, input int low);
        tick();
        chk("ack", req_ack, 32'(1) << win);
        chk("start", uart_tx_start, 1);
        chk("data", uart_transmit_data, req_data[win*8 +: 8]);
        chk("grant", grant_id, win);
        chk("busy_launch", arb_busy, 1);
        lg_m = win;
        if (!hold) req_valid[win] = 1'b0;
        tick();
        chk("start_pulse", uart_tx_start, 0);
        chk("ack_pulse", req_ack, 0);
        repeat (lag) tick();
        uart_tx_ready = 1'b0;
        repeat (low) tick();
        chk("ack_busy", req_ack, 0);
        chk("busy_wait", arb_busy, 1);
        uart_tx_ready = 1'b1;
        tick();
        chk("busy_fall", arb_busy, 0);
    endtask

    initial begin
        uart_reset    = 1'b1;
        req_valid     = '0;
        req_data      = '0;
        uart_tx_ready = 1'b1;
        do_reset();
        chk("rst_ack", req_ack, 0);
        chk("rst_start", uart_tx_start, 0);
        chk("rst_data", uart_transmit_data, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", arb_busy, 0);
        chk("rst_err", timeout_err, 0);

        // Single request.
        req_data[23:16] = 8'hA5;
        req_valid       = 4'b0100;
        run_frame(2, 1'b0, 1, LONG_LOW);

        // Fairness with everyone requesting continuously.
        do_reset();
        req_data  = 32'h44332211;
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) run_frame(order[i], 1'b1, 0, 10);
        req_valid = '0;

        // Wrap and skip.
        do_reset();
        req_valid = 4'b0010;
        run_frame(1, 1'b0, 0, 3);
        req_valid = 4'b1010;
        run_frame(3, 1'b0, 0, 3);
        run_frame(1, 1'b0, 0, 3);

        // Ready held low blocks the grant.
        uart_tx_ready = 1'b0;
        req_valid     = 4'b0001;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("noready_start", uart_tx_start, 0);
            chk("noready_ack", req_ack, 0);
        end
        uart_tx_ready = 1'b1;
        run_frame(0, 1'b0, 0, 3);

        // Reset while waiting for the frame to finish.
        req_valid = 4'b1111;
        w = model_pick(req_valid, lg_m);
        tick();
        chk("mid_ack", req_ack, 32'(1) << w);
        tick();
        uart_tx_ready = 1'b0;
        tick();
        tick();
        uart_reset = 1'b1;
        tick();
        chk("mid_rst_ack", req_ack, 0);
        chk("mid_rst_start", uart_tx_start, 0);
        chk("mid_rst_data", uart_transmit_data, 0);
        chk("mid_rst_grant", grant_id, 0);
        chk("mid_rst_busy", arb_busy, 0);
        uart_reset = 1'b0;
        lg_m = N - 1;
        repeat (3) begin
            tick();
            chk("mid_hold_start", uart_tx_start, 0);
        end
        uart_tx_ready = 1'b1;
        run_frame(0, 1'b1, 1, 3);
        req_valid = '0;

        // Ready stuck high after the start pulse.
        do_reset();
        req_valid = 4'b0001;
        tick();
        chk("to_ack", req_ack, 1);
        req_valid = '0;
        lg_m = 0;
        tick();
        repeat (19) tick();
        chk("to_busy_pre", arb_busy, 1);
        chk("to_err_pre", timeout_err, 0);
        tick();
`ifdef UART_ARB_TIMEOUT_EN
        chk("to_busy", arb_busy, 0);
        chk("to_err", timeout_err, 1);
`else
        chk("to_busy", arb_busy, 1);
        chk("to_err", timeout_err, 0);
`endif
        uart_tx_ready = 1'b0;
        tick();
        tick();
        uart_tx_ready = 1'b1;
        tick();
        chk("to_idle", arb_busy, 0);
        req_valid = 4'b0010;
        run_frame(1, 1'b0, 0, 2);
`ifdef UART_ARB_TIMEOUT_EN
        chk("to_sticky", timeout_err, 1);
`else
        chk("to_sticky", timeout_err, 0);
`endif

        // Randomized traffic against the reference model.
        for (int f = 0; f < 60; f++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_data[i*8 +: 8] = 8'($urandom);
                    req_valid[i]       = 1'b1;
                end
            end
            if (req_valid == '0) begin
                w = $urandom_range(0, N - 1);
                req_data[w*8 +: 8] = 8'($urandom);
                req_valid[w]       = 1'b1;
            end
            w = model_pick(req_valid, lg_m);
            run_frame(w, $urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(1, 6));
            if ($urandom_range(0, 4) == 0) req_valid[$urandom_range(0, N - 1)] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter of the uart_rx_tx datapath among NUM_REQ byte producers, e.g. a status reporter, an echo path and a debug logger.
- Round-robin arbitration picks one requester per frame.
- The block latches the winner's byte, drives the transmitter's start/data inputs and tracks uart_tx_ready until the frame completes.
- Sits between the producers and uart_rx_tx inside the top-level wrapper.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 28'd200000, cycles allowed per wait phase before abort. Used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk_10ns  input  1  system clock.
- uart_reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte pending; held until its req_ack.
- req_data  input  NUM_REQ*8  byte of requester i at [8i+7:8i]; stable while req_valid[i]=1.
- req_ack  output  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted.
- uart_tx_ready  input  1  transmitter idle, from uart_rx_tx.
- uart_tx_start  output  1  one-cycle start pulse to the transmitter.
- uart_transmit_data  output  8  byte to the transmitter; held for the whole frame.
- grant_id  output  $clog2(NUM_REQ)  index of last granted requester.
- arb_busy  output  1  high in any state other than IDLE.
- timeout_err  output  1  sticky abort flag; constant 0 without the macro.

Behaviour:
- Reset values: all outputs are registered and reset to 0. State resets to IDLE. Round-robin pointer last_grant resets to NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE: when uart_tx_ready=1 and |req_valid at a clock edge:
  - winner = first set req_valid at or after (last_grant+1) mod NUM_REQ, wrapping.
  - uart_transmit_data <= winner's byte; req_ack <= onehot(winner); grant_id, last_grant <= winner; uart_tx_start <= 1; go to LAUNCH.
  - If uart_tx_ready=0, or no request, stay in IDLE with no ack.
- LAUNCH: lasts exactly one cycle, the cycle in which uart_tx_start=1 and req_ack is high. Next edge: clear start and ack, go to WAIT_BUSY.
- WAIT_BUSY: on uart_tx_ready=0, go to WAIT_DONE. This guards against a ready signal that lags the start pulse.
- WAIT_DONE: on uart_tx_ready=1, go to IDLE.
- Latency:
  - Request seen at edge T with the block idle and ready high: start and ack are high during cycle T+1.
  - Back-to-back frames: the next grant is evaluated in the first IDLE cycle after ready returns high. Gap is 1 cycle after ready rises.
- Requests are sampled only in IDLE.
  - A req_valid that drops before its ack is simply not served.
  - A requester that keeps req_valid high after its ack is treated as a new request and competes again under round-robin.
- uart_transmit_data does not change outside the IDLE→LAUNCH transition.
- Simultaneous requests: exactly one ack per frame, never two.
- Reset mid-frame: the block returns to IDLE immediately and the in-flight frame is abandoned. No new start is issued until uart_tx_ready=1.
- NUM_REQ not a power of 2: grant_id never exceeds NUM_REQ-1, and pointer wrap uses an explicit compare, not an overflow.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - A 28-bit counter clears on entry to WAIT_BUSY and WAIT_DONE and increments each cycle spent there.
  - On reaching TIMEOUT_CYCLES-1 the FSM goes to IDLE and timeout_err <= 1.
  - timeout_err is sticky until uart_reset. Arbitration continues normally afterwards.
- Undefined: no counter is built, the wait states wait indefinitely, and timeout_err is tied to 0.

Decomposition:
- Package uart_arb_pkg:
  - state typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE}.
  - localparam UART_DATA_W = 8.
- Sub-module uart_rr_pick: purely combinational round-robin selector.
  - Inputs: req vector, last_grant.
  - Outputs: winner index, any_req.
  - Reusable for the RX-side consumer mux.

Test Plan:
- Single request: after reset, req_valid=4'b0100, data[23:16]=8'hA5, ready=1 → next cycle req_ack=4'b0100, uart_tx_start=1 for exactly 1 cycle, uart_transmit_data=8'hA5, grant_id=2. Drop ready 2 cycles later and raise it after 100 cycles → arb_busy falls 1 cycle after ready rises.
- Fairness: req_valid=4'b1111 held, ready model busy for 10 cycles per frame → grant order 0,1,2,3,0,1; exactly one ack per frame.
- Wrap and skip: last_grant=3, req_valid=4'b0010 → grant 1. Then req_valid=4'b1010 → grant 3 before 1.
- Ready low: ready=0 with req_valid=4'b0001 for 50 cycles → no start and no ack. Raise ready → start on the following cycle.
- Reset mid-frame: assert uart_reset in WAIT_DONE → all outputs 0, state IDLE, next grant goes to requester 0 among 4'b1111.
- Timeout (macro on, TIMEOUT_CYCLES=28'd20): ready stuck at 1 after start → after 20 cycles in WAIT_BUSY, return to IDLE with timeout_err=1 sticky. Macro off → block stays in WAIT_BUSY and timeout_err stays 0.
